// File: rtl/lrf_pkg.sv
// Shared sizing helpers and the pixel-unpack function for the LRF fusion engine.
package lrf_pkg;

  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int MAX_DATA_W      = 4096;

  function automatic int beats_f(input int dim, input int ppb);
    return (dim * dim) / ppb;
  endfunction

  function automatic int shift_f(input int fuse_count);
    return $clog2(fuse_count);
  endfunction

  function automatic int acc_w_f(input int pw, input int fuse_count);
    return pw + $clog2(fuse_count);
  endfunction

  function automatic int addr_w_f(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  // Pixel idx of a packed beat, zero-extended to 32 bits.
  function automatic logic [31:0] px_unpack(input logic [MAX_DATA_W-1:0] data,
                                            input int idx, input int pw);
    return 32'(data >> (idx * pw)) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/lrf_accum_fuse_if.sv
// Input and output AXI-Stream channels of the fusion engine.
interface lrf_accum_fuse_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/lrf_accum_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module lrf_accum_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lrf_accum_fuse.sv
// Multi-frame fusion engine: accumulates FUSE_COUNT frames per pixel and streams the average.
// Build option LRF_ROUND_EN: round half up with saturation instead of truncation.
module lrf_accum_fuse
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIXEL_WIDTH     = PIXEL_WIDTH_DEF,
  parameter int IMAGE_DIM       = 512,
  parameter int FUSE_COUNT      = 16,
  parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  lrf_accum_fuse_if.slave               axis,
  output logic [$clog2(FUSE_COUNT)-1:0] frame_idx,
  output logic                          tlast_err
);
  localparam int BEATS  = beats_f(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int SHIFT  = shift_f(FUSE_COUNT);
  localparam int ACC_W  = acc_w_f(PIXEL_WIDTH, FUSE_COUNT);
  localparam int ACC_W1 = ACC_W + 1;
  localparam int AW     = addr_w_f(BEATS);
  localparam int FW     = $clog2(FUSE_COUNT);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FUSE_COUNT - 1);
  localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
`ifdef LRF_ROUND_EN
  localparam logic [ACC_W:0] RND = ACC_W1'(1) << (SHIFT - 1);
`endif

  logic [AW-1:0] beat_q, beat_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          s1_vld_q, s1_last_q;
  logic [AW-1:0] s1_addr_q;
  logic [FW-1:0] s1_frame_q;
  logic          m_vld_q, m_vld_d, m_last_q, err_q;
  logic [PIXELS_PER_BEAT-1:0][PIXEL_WIDTH-1:0] in_px, s1_px_q, avg_px, m_px_q;
  logic [PIXELS_PER_BEAT-1:0][ACC_W-1:0]       rd_acc, sum_acc, wr_acc;
  logic step, out_free, s1_final, s1_stall, s1_to_out, ram_we;

  assign step      = axis.s_axis_tvalid & axis.s_axis_tready;
  assign out_free  = ~m_vld_q | axis.m_axis_tready;
  assign s1_final  = (s1_frame_q == LAST_FRAME);
  assign s1_stall  = s1_vld_q & s1_final & ~out_free;
  assign s1_to_out = s1_vld_q & s1_final & out_free;
  assign ram_we    = s1_vld_q & ~s1_final;

  // A stalled final beat also blocks the first beat of the next group.
  assign axis.s_axis_tready = ~s1_stall & ((frame_q != LAST_FRAME) | out_free);

  for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_px
    assign in_px[i]   = PIXEL_WIDTH'(px_unpack(MAX_DATA_W'(axis.s_axis_tdata), i, PIXEL_WIDTH));
    assign sum_acc[i] = rd_acc[i] + ACC_W'(s1_px_q[i]);
    assign wr_acc[i]  = (s1_frame_q == '0) ? ACC_W'(s1_px_q[i]) : sum_acc[i];
`ifdef LRF_ROUND_EN
    logic [ACC_W:0] rnd_sh;
    assign rnd_sh    = ({1'b0, sum_acc[i]} + RND) >> SHIFT;
    assign avg_px[i] = (|rnd_sh[ACC_W:PIXEL_WIDTH]) ? '1 : rnd_sh[PIXEL_WIDTH-1:0];
`else
    assign avg_px[i] = PIXEL_WIDTH'(sum_acc[i] >> SHIFT);
`endif
  end

  lrf_accum_ram #(
    .DEPTH (BEATS),
    .WIDTH (ACC_W * PIXELS_PER_BEAT),
    .AW    (AW)
  ) u_ram (
    .clk_i   (s_axis_aclk),
    .we_i    (ram_we),
    .waddr_i (s1_addr_q),
    .wdata_i (wr_acc),
    .re_i    (step),
    .raddr_i (beat_q),
    .rdata_o (rd_acc)
  );

  always_comb begin
    beat_d  = beat_q;
    frame_d = frame_q;
    m_vld_d = m_vld_q;
    if (step) begin
      if (beat_q == LAST_BEAT) begin
        beat_d  = '0;
        frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FW'(1);
      end else begin
        beat_d = beat_q + AW'(1);
      end
    end
    if (s1_to_out)                m_vld_d = 1'b1;
    else if (axis.m_axis_tready)  m_vld_d = 1'b0;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      beat_q   <= '0;
      frame_q  <= '0;
      s1_vld_q <= 1'b0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      m_px_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      frame_q <= frame_d;
      m_vld_q <= m_vld_d;
      if (step) begin
        s1_vld_q <= 1'b1;
        if (axis.s_axis_tlast != (beat_q == LAST_BEAT)) err_q <= 1'b1;
      end else if (!s1_stall) begin
        s1_vld_q <= 1'b0;
      end
      if (s1_to_out) begin
        m_px_q   <= avg_px;
        m_last_q <= s1_last_q;
      end
    end
  end

  // Stage-1 payload only moves on step, so it is naturally held across stalls.
  always_ff @(posedge s_axis_aclk) begin
    if (step) begin
      s1_px_q    <= in_px;
      s1_addr_q  <= beat_q;
      s1_frame_q <= frame_q;
      s1_last_q  <= (beat_q == LAST_BEAT);
    end
  end

  assign axis.m_axis_tdata  = DATA_WIDTH'(m_px_q);
  assign axis.m_axis_tvalid = m_vld_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign frame_idx          = frame_q;
  assign tlast_err          = err_q;
endmodule

// File: tb/tb_lrf_accum_fuse.sv
// Randomized bench for lrf_accum_fuse against a per-address averaging model.
module tb_lrf_accum_fuse;
  localparam int PPB = 2, PW = 8, DIM = 4, FC = 4;
  localparam int DW = PPB * PW, BEATS = DIM * DIM / PPB;
`ifdef LRF_ROUND_EN
  localparam int RND = FC / 2;
`else
  localparam int RND = 0;
`endif

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] frame_idx;
  logic       tlast_err;

  lrf_accum_fuse_if #(.DATA_WIDTH(DW)) axis ();

  lrf_accum_fuse #(
    .PIXELS_PER_BEAT (PPB),
    .PIXEL_WIDTH     (PW),
    .IMAGE_DIM       (DIM),
    .FUSE_COUNT      (FC)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .axis          (axis),
    .frame_idx     (frame_idx),
    .tlast_err     (tlast_err)
  );

  always #5 clk = ~clk;

  beat_t in_q[$], exp_q[$];
  int    acc[BEATS][PPB];
  int    mdl_beat, mdl_frame, accepts, outs, cyc;
  bit    exp_err;
  int    total, bad;
  int    vld_pct = 100, rdy_pct = 100, hold_at = -1, hold_len = 0;
  int    t_first_final = -1, t_first_out = -1;
  bit    sready_low_seen, prev_stall;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: per-address running sum; final frame yields rounded average.
  task automatic mdl_accept(input beat_t b);
    logic [DW-1:0] o;
    int px, avg;
    o = '0;
    if (b.l != (mdl_beat == BEATS - 1)) exp_err = 1'b1;
    for (int p = 0; p < PPB; p++) begin
      px = int'(b.d[p*PW +: PW]);
      acc[mdl_beat][p] = (mdl_frame == 0) ? px : acc[mdl_beat][p] + px;
      avg = (acc[mdl_beat][p] + RND) / FC;
      if (avg > 255) avg = 255;
      o[p*PW +: PW] = PW'(avg);
    end
    if (mdl_frame == FC - 1) exp_q.push_back('{d: o, l: (mdl_beat == BEATS - 1)});
    accepts++;
    if (mdl_beat == BEATS - 1) begin
      mdl_beat  = 0;
      mdl_frame = (mdl_frame + 1) % FC;
    end else begin
      mdl_beat++;
    end
  endtask

  task automatic push_group(input int pv[FC], input int bad_f, input int bad_b);
    beat_t b;
    for (int f = 0; f < FC; f++)
      for (int bt = 0; bt < BEATS; bt++) begin
        for (int p = 0; p < PPB; p++)
          b.d[p*PW +: PW] = (pv[f] < 0) ? PW'($urandom_range(255)) : PW'(pv[f]);
        b.l = (bt == BEATS - 1) || (f == bad_f && bt == bad_b);
        in_q.push_back(b);
      end
  endtask

  task automatic step_cycle();
    bit v, r;
    beat_t e;
    @(negedge clk);
    v = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
    r = ($urandom_range(99) < rdy_pct);
    if (hold_at == outs && hold_len > 0) begin
      r = 1'b0;
      hold_len--;
    end
    axis.s_axis_tvalid = v;
    axis.s_axis_tdata  = v ? in_q[0].d : DW'($urandom);
    axis.s_axis_tlast  = v ? in_q[0].l : 1'b0;
    axis.m_axis_tready = r;
    #4;
    chk("frame_idx", frame_idx, mdl_frame);
    chk("tlast_err", tlast_err, exp_err);
    if (prev_stall) begin
      chk("stall_valid", axis.m_axis_tvalid, 1);
      chk("stall_data", axis.m_axis_tdata, prev_d);
      chk("stall_last", axis.m_axis_tlast, prev_l);
    end
    if (hold_len > 0 && axis.m_axis_tvalid && mdl_frame == FC - 1 && !axis.s_axis_tready)
      sready_low_seen = 1'b1;
    if (v && axis.s_axis_tready) begin
      if (mdl_frame == FC - 1 && t_first_final < 0) t_first_final = cyc;
      mdl_accept(in_q.pop_front());
    end
    if (axis.m_axis_tvalid) begin
      if (t_first_out < 0) t_first_out = cyc;
      if (r) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("odata", axis.m_axis_tdata, e.d);
          chk("olast", axis.m_axis_tlast, e.l);
        end
        outs++;
      end
    end
    prev_stall = axis.m_axis_tvalid && !r;
    prev_d     = axis.m_axis_tdata;
    prev_l     = axis.m_axis_tlast;
    cyc++;
  endtask

  task automatic run(input int maxc, input int stop_acc);
    int n = 0;
    while (n < maxc) begin
      if (stop_acc >= 0 ? (accepts >= stop_acc) : (in_q.size() == 0 && exp_q.size() == 0)) break;
      step_cycle();
      n++;
    end
    if (stop_acc >= 0) chk("reach_accepts", accepts, stop_acc);
    else               chk("drained", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    mdl_beat = 0;
    mdl_frame = 0;
    exp_err = 1'b0;
    prev_stall = 1'b0;
    #4;
    chk("rst_frame_idx", frame_idx, 0);
    chk("rst_m_tvalid", axis.m_axis_tvalid, 0);
    chk("rst_m_tlast", axis.m_axis_tlast, 0);
    chk("rst_m_tdata", axis.m_axis_tdata, 0);
    chk("rst_tlast_err", tlast_err, 0);
    chk("rst_s_tready", axis.s_axis_tready, 1);
  endtask

  initial begin
    int o0, a0;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b1;
    do_reset();

    // Flat frames of 10 with continuous flow: checks value, tlast position and latency.
    o0 = outs;
    push_group('{10, 10, 10, 10}, -1, -1);
    run(400, -1);
    chk("n_out_flat", outs - o0, BEATS);
    chk("latency", t_first_out - t_first_final, 2);

    // 1,2,2,2 sums to 7: truncation gives 1, rounding gives 2.
    o0 = outs;
    push_group('{1, 2, 2, 2}, -1, -1);
    run(400, -1);
    chk("n_out_round", outs - o0, BEATS);

    // Full-scale pixels must not wrap.
    push_group('{255, 255, 255, 255}, -1, -1);
    run(400, -1);

    // Downstream stall of 5 cycles in the middle of the final frame.
    o0 = outs;
    sready_low_seen = 1'b0;
    hold_at  = outs + 3;
    hold_len = 5;
    push_group('{-1, -1, -1, -1}, -1, -1);
    run(400, -1);
    chk("sready_drop", sready_low_seen, 1);
    chk("n_out_stall", outs - o0, BEATS);
    hold_at = -1;

    // Early tlast in frame 1: sticky error, counters keep going.
    push_group('{5, 6, 7, 8}, 1, 3);
    run(400, -1);
    chk("err_sticky", tlast_err, 1);

    // Reset at frame 2 beat 5, then a fresh group of 40s.
    a0 = accepts;
    push_group('{9, 9, 9, 9}, -1, -1);
    run(400, a0 + 2 * BEATS + 5);
    do_reset();
    o0 = outs;
    push_group('{40, 40, 40, 40}, -1, -1);
    run(400, -1);
    chk("n_out_after_rst", outs - o0, BEATS);

    // Random data with random gaps on both sides.
    vld_pct = 70;
    rdy_pct = 60;
    push_group('{-1, -1, -1, -1}, -1, -1);
    push_group('{-1, -1, -1, -1}, -1, -1);
    run(3000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
